// File: rtl/reg_bank_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_mp_if
// Desc     : Write, read, debug and clear-control bus for reg_bank_mp.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_bank_mp_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(DEPTH);

  logic                   we;
  logic [AW-1:0]          waddr;
  logic [WIDTH-1:0]       wdata;
  logic [NREAD*AW-1:0]    raddr;
  logic [NREAD*WIDTH-1:0] rdata;
  logic                   clr_req;
  logic                   busy;
  logic [AW-1:0]          dbg_addr;
  logic [WIDTH-1:0]       salida;

  modport master (
    output we, waddr, wdata, raddr, clr_req, dbg_addr,
    input  rdata, busy, salida
  );

  modport slave (
    input  we, waddr, wdata, raddr, clr_req, dbg_addr,
    output rdata, busy, salida
  );
endinterface : reg_bank_mp_if
`default_nettype wire

// File: rtl/reg_bank_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_mp
// Desc     : Multi-read-port register bank with debug read and sequenced clear.
// Options  : REG_BANK_BYPASS_EN - read ports return wdata on same-cycle
//            same-address write (write-first); default is read-first.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_mp #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NREAD = 2,
  parameter int ZERO0 = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_bank_mp_if.slave   bus
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW-1:0] c_LAST  = AW'(DEPTH - 1);
  localparam bit            c_ZERO0 = (ZERO0 != 0);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  logic [WIDTH-1:0] m [DEPTH];

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_ptr, w_ptr_nxt;
  logic          w_clr_en;
  logic          w_wr_en;
  logic [WIDTH-1:0] r_salida;

  // An address is live when it maps to a real entry that is not the hardwired zero.
  function automatic logic f_live(input logic [AW-1:0] a);
    return (32'(a) < 32'(DEPTH)) && !(c_ZERO0 && (a == '0));
  endfunction

  assign w_wr_en  = bus.we && (r_state == S_IDLE) && !bus.clr_req && f_live(bus.waddr);
  assign bus.busy = (r_state == S_CLEAR);

  // Clear engine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_clr_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.clr_req) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      S_CLEAR: begin
        w_clr_en = 1'b1;
        if (r_ptr == c_LAST) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // Storage array; clear and write never coincide since writes require IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m[i] <= '0;
      end
    end else if (w_clr_en) begin
      m[r_ptr] <= '0;
    end else if (w_wr_en) begin
      m[bus.waddr] <= bus.wdata;
    end
  end

  generate
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [AW-1:0]    w_ra;
      logic [WIDTH-1:0] w_rd_nxt;
      logic [WIDTH-1:0] r_rd;

      assign w_ra = bus.raddr[k*AW +: AW];

`ifdef REG_BANK_BYPASS_EN
      assign w_rd_nxt = !f_live(w_ra)                       ? '0        :
                        (w_wr_en && (bus.waddr == w_ra))    ? bus.wdata :
                                                              m[w_ra];
`else
      assign w_rd_nxt = f_live(w_ra) ? m[w_ra] : '0;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd <= '0;
        end else begin
          r_rd <= w_rd_nxt;
        end
      end

      assign bus.rdata[k*WIDTH +: WIDTH] = r_rd;
    end
  endgenerate

  // Debug read port, always read-first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_salida <= '0;
    end else begin
      r_salida <= f_live(bus.dbg_addr) ? m[bus.dbg_addr] : '0;
    end
  end

  assign bus.salida = r_salida;

endmodule : reg_bank_mp
`default_nettype wire

// File: tb/tb_reg_bank_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_mp
// Desc     : Directed scoreboard bench for reg_bank_mp (32x32, two read ports).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank_mp;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int NREAD = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  reg_bank_mp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD)) bus ();

  reg_bank_mp #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .NREAD(NREAD),
    .ZERO0(1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [WIDTH-1:0] w_rd0, w_rd1;
  assign w_rd0 = bus.rdata[WIDTH-1:0];
  assign w_rd1 = bus.rdata[2*WIDTH-1:WIDTH];

  task automatic push(input string tag, input logic [WIDTH-1:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [WIDTH-1:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty: observed %h required <none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [WIDTH-1:0] d);
    bus.we    = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    step();
    bus.we    = 1'b0;
  endtask

  int cnt;

  initial begin
    bus.we       = 1'b0;
    bus.waddr    = '0;
    bus.wdata    = '0;
    bus.raddr    = '0;
    bus.clr_req  = 1'b0;
    bus.dbg_addr = '0;

    // Reset values
    #3;
    push("rst_busy", 0);   pop_check(WIDTH'(bus.busy));
    push("rst_salida", 0); pop_check(bus.salida);
    push("rst_rdata0", 0); pop_check(w_rd0);
    push("rst_rdata1", 0); pop_check(w_rd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Reads of an empty bank
    bus.raddr = {5'd31, 5'd5};
    push("empty_rd0", 0);
    push("empty_rd1", 0);
    push("empty_busy", 0);
    push("empty_salida", 0);
    step();
    pop_check(w_rd0);
    pop_check(w_rd1);
    pop_check(WIDTH'(bus.busy));
    pop_check(bus.salida);

    // Basic write then read on port 0 and the debug port
    wr(5'd7, 32'hDEAD_BEEF);
    bus.raddr[4:0] = 5'd7;
    bus.dbg_addr   = 5'd7;
    push("wr7_rd0", 32'hDEAD_BEEF);
    push("wr7_salida", 32'hDEAD_BEEF);
    step();
    pop_check(w_rd0);
    pop_check(bus.salida);

    // Entry 0 is hardwired to zero
    wr(5'd0, 32'h1234_5678);
    bus.raddr[4:0] = 5'd0;
    bus.dbg_addr   = 5'd0;
    push("zero0_rd0", 0);
    push("zero0_salida", 0);
    step();
    pop_check(w_rd0);
    pop_check(bus.salida);

    // Same-cycle write/read collision on port 1; debug port never bypasses
    bus.we         = 1'b1;
    bus.waddr      = 5'd3;
    bus.wdata      = 32'h1234_5678;
    bus.raddr[9:5] = 5'd3;
    bus.dbg_addr   = 5'd3;
`ifdef REG_BANK_BYPASS_EN
    push("collide_rd1", 32'h1234_5678);
`else
    push("collide_rd1", 0);
`endif
    push("collide_salida", 0);
    step();
    bus.we = 1'b0;
    pop_check(w_rd1);
    pop_check(bus.salida);
    push("after_collide_rd1", 32'h1234_5678);
    push("after_collide_salida", 32'h1234_5678);
    step();
    pop_check(w_rd1);
    pop_check(bus.salida);

    // Fill the bank, then a full clear with a blocked write in the middle
    for (int a = 1; a < DEPTH; a++) begin
      wr(5'(a), 32'hFFFF_FFFF);
    end
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    push("clr_busy_rise", 1);
    pop_check(WIDTH'(bus.busy));
    cnt = 1;
    while (cnt < 40) begin
      if (cnt == 5) begin
        bus.raddr[9:5] = 5'd31;
        push("clear_pending_rd1", 32'hFFFF_FFFF);
      end
      bus.we    = (cnt >= 10) && (cnt <= 14);
      bus.waddr = 5'd9;
      bus.wdata = 32'h5555_5555;
      step();
      if (cnt == 5) pop_check(w_rd1);
      if (bus.busy) cnt++;
      else break;
    end
    bus.we = 1'b0;
    push("clr_busy_len", 32);
    pop_check(WIDTH'(cnt));
    for (int a = 0; a < DEPTH; a++) begin
      bus.raddr[4:0] = 5'(a);
      push($sformatf("cleared_m%0d", a), 0);
      step();
      pop_check(w_rd0);
    end

    // Reset in the middle of a clear
    wr(5'd20, 32'hCAFE_0020);
    wr(5'd31, 32'h3131_3131);
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    for (int i = 0; i < 11; i++) step();
    bus.raddr    = {5'd31, 5'd20};
    bus.dbg_addr = 5'd20;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    push("midrst_busy", 0);   pop_check(WIDTH'(bus.busy));
    push("midrst_rd0", 0);    pop_check(w_rd0);
    push("midrst_rd1", 0);    pop_check(w_rd1);
    push("midrst_salida", 0); pop_check(bus.salida);
    rst_n = 1'b1;
    push("postrst_rd0", 0);
    push("postrst_rd1", 0);
    push("postrst_busy", 0);
    step();
    pop_check(w_rd0);
    pop_check(w_rd1);
    pop_check(WIDTH'(bus.busy));
    wr(5'd20, 32'h2020_2020);
    push("postrst_wr20", 32'h2020_2020);
    step();
    pop_check(w_rd0);

    // clr_req together with a write, plus a re-request during busy
    bus.clr_req = 1'b1;
    bus.we      = 1'b1;
    bus.waddr   = 5'd4;
    bus.wdata   = 32'hA5A5_A5A5;
    step();
    bus.clr_req = 1'b0;
    bus.we      = 1'b0;
    push("clr2_busy_rise", 1);
    pop_check(WIDTH'(bus.busy));
    bus.raddr[4:0] = 5'd4;
    push("clr_wins_m4", 0);
    cnt = 1;
    while (cnt < 40) begin
      bus.clr_req = (cnt == 8);
      step();
      if (cnt == 1) pop_check(w_rd0);
      if (bus.busy) cnt++;
      else break;
    end
    bus.clr_req = 1'b0;
    push("clr2_busy_len", 32);
    pop_check(WIDTH'(cnt));
    bus.raddr = {5'd20, 5'd4};
    push("clr2_m4", 0);
    push("clr2_m20", 0);
    step();
    pop_check(w_rd0);
    pop_check(w_rd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_reg_bank_mp
`default_nettype wire

// File: doc/reg_bank_mp.md
Name: reg_bank_mp

Overview:
Parametrised multi-read-port register bank, the successor to the fixed 32x32 single-port bank used by the A10 datapath. It has one write port, NREAD registered read ports and a debug read port driving `salida`. A sequenced clear engine wipes the array one entry per cycle on request. It sits between decode and ALU in the next-generation datapath; benches preload `m` via hierarchical `$readmemb`.

Parameters:
WIDTH, 32, data bits per entry
DEPTH, 32, number of entries (>=2); AW = $clog2(DEPTH) localparam
NREAD, 2, number of read ports (>=1)
ZERO0, 1, 1: entry 0 hardwired to zero (writes ignored, reads 0)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
we  in  1  write enable
waddr  in  AW  write address
wdata  in  WIDTH  write data
raddr  in  NREAD*AW  read addresses, port k at [k*AW +: AW]
rdata  out  NREAD*WIDTH  read data, port k at [k*WIDTH +: WIDTH]
clr_req  in  1  pulse: start full-array clear
busy  out  1  clear in progress
dbg_addr  in  AW  debug read address
salida  out  WIDTH  registered debug read of m[dbg_addr]

Behaviour:
- Reset (rst_n low, async): all m entries = 0, rdata = 0, salida = 0, busy = 0, FSM = IDLE, clear pointer = 0.
- Write qualifies when we=1, busy=0, clr_req=0, waddr<DEPTH, and !(ZERO0 && waddr==0). A qualified write updates m[waddr] at the rising edge; otherwise the write is dropped silently.
- Read port k: rdata_k <= m[raddr_k] at every rising edge (1-cycle latency, no enable).
  - raddr_k >= DEPTH gives 0.
  - With ZERO0=1, address 0 gives 0.
  - Same-cycle write to the same address: the returned value depends on BYPASS_EN (see below).
- salida <= m[dbg_addr] every edge, with the same range and zero rules as read ports. salida never bypasses.
- Clear FSM states:
  - IDLE: clr_req=1 -> CLEAR; ptr <= 0; busy <= 1.
  - CLEAR: each edge m[ptr] <= 0 and ptr <= ptr+1. When ptr==DEPTH-1, that entry is cleared, the FSM goes to IDLE and busy <= 0.
  - busy is high for exactly DEPTH cycles.
- During CLEAR:
  - clr_req is ignored (no restart).
  - Writes are dropped.
  - Reads return the current array, including entries not yet cleared.
- clr_req and we in the same IDLE cycle: clear wins and the write is dropped.
- rst_n asserted mid-CLEAR: immediate return to the reset state; the clear is not resumed.
- Pointer never wraps past DEPTH-1; a non-power-of-two DEPTH must still stop at DEPTH-1.

Optional Feature:
Macro `REG_BANK_BYPASS_EN`.
- Defined: when a qualified write and a read on port k target the same address in the same cycle, rdata_k <= wdata (write-first).
- Undefined: rdata_k <= the old m contents (read-first).
- salida is unaffected in both builds.

Test Plan:
1. Reset, then raddr0=5 and raddr1=31 -> rdata0=0, rdata1=0 next cycle; busy=0, salida=0.
2. Write 0xDEADBEEF to addr 7, next cycle raddr0=7 -> rdata0=0xDEADBEEF one edge later; dbg_addr=7 -> salida=0xDEADBEEF.
3. Write 0x12345678 to addr 0 with ZERO0=1 -> raddr0=0 reads 0. Write addr 3 while raddr1=3 in the same cycle -> rdata1=0x12345678 with REG_BANK_BYPASS_EN, prior value (0) without it.
4. Preload all entries to 0xFFFFFFFF, pulse clr_req -> busy high exactly 32 cycles. we=1 to addr 9 at cycle 10 is dropped. After busy falls, every entry reads 0.
5. Mid-clear (cycle 12), pull rst_n low for 1 ns -> busy=0 at once, all outputs 0, FSM in IDLE; a later write and read of addr 20 works normally.
6. Raise clr_req with we=1, waddr=4, wdata=0xA5A5A5A5 -> write dropped, m[4]=0 after clear; a second clr_req during busy does not extend busy beyond 32 cycles.
